// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------------------------
// btn_conditioner
//
// Multi-channel push-button conditioner. Each channel is fully independent and has:
//   - a SYNC_STAGES-deep synchroniser on the raw pin,
//   - a symmetric debounce counter (the same qualification time for press and release),
//   - registered one-cycle press / release pulses, set on the edge the debounced level changes,
//   - an optional hold-to-repeat generator (compile-time macro BTN_AUTOREPEAT_EN).
//
// Configuration macro:
//   BTN_AUTOREPEAT_EN  defined   : per-channel IDLE/DELAY/REPEAT FSM drives o_btn_repeat
//                      undefined : no repeat logic, o_btn_repeat tied to 0
//
// Parameters:
//   N_CH              number of button channels (>= 1)
//   SYNC_STAGES       synchroniser depth (>= 2)
//   DEBOUNCE_CYC      consecutive stable cycles needed to accept a new level (>= 1)
//   REPEAT_DELAY_CYC  cycles from the press pulse to the first repeat pulse
//   REPEAT_RATE_CYC   cycles between subsequent repeat pulses
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_btn          raw asynchronous button pins, 1 = pressed
//   o_btn_level    debounced level per channel
//   o_btn_press    one-cycle pulse on a debounced 0->1 transition
//   o_btn_release  one-cycle pulse on a debounced 1->0 transition
//   o_btn_repeat   one-cycle auto-repeat pulse (0 without BTN_AUTOREPEAT_EN)
// ---------------------------------------------------------------------------------------------
module btn_conditioner #(
  parameter int unsigned N_CH             = 4,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned DEBOUNCE_CYC     = 500_000,
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 10_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_btn_level,
  output logic [N_CH-1:0] o_btn_press,
  output logic [N_CH-1:0] o_btn_release,
  output logic [N_CH-1:0] o_btn_repeat
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  // Last count value before a differing level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  // Elaboration-time parameter sanity checks.
  if (N_CH < 1) begin : g_chk_nch
    $error("btn_conditioner: N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("btn_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_chk_deb
    $error("btn_conditioner: DEBOUNCE_CYC must be >= 1");
  end
  if ((REPEAT_DELAY_CYC < 1) || (REPEAT_RATE_CYC < 1)) begin : g_chk_rpt
    $error("btn_conditioner: REPEAT_DELAY_CYC and REPEAT_RATE_CYC must be >= 1");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_SPAN =
      (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned RPT_W = $clog2(RPT_SPAN + 1);
  localparam logic [RPT_W-1:0] DLY_MAX  = RPT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPT_W-1:0] RATE_MAX = RPT_W'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StRepeat = 2'd2
  } rpt_state_e;
`endif

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch

    // -----------------------------------------------------------------------------------------
    // Synchroniser
    // -----------------------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn[gi]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------------------------
    // Debounce
    // -----------------------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_diff;
    logic             w_done;
    logic             w_rise;
    logic             w_fall;

    always_comb begin
      w_diff = (w_s != r_level);
      // Level is accepted once the differing value has survived DEBOUNCE_CYC edges in a row.
      w_done = w_diff && (r_cnt == CNT_MAX);
      w_rise = w_done && w_s;
      w_fall = w_done && !w_s;
      // Any single matching cycle restarts qualification; counter clears on acceptance too,
      // so it never wraps.
      if (!w_diff || w_done) begin
        w_cnt_d = '0;
      end else begin
        w_cnt_d = r_cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_d;
        if (w_done) begin
          r_level <= w_s;
        end
        r_press   <= w_rise;
        r_release <= w_fall;
      end
    end

    assign o_btn_level[gi]   = r_level;
    assign o_btn_press[gi]   = r_press;
    assign o_btn_release[gi] = r_release;

`ifdef BTN_AUTOREPEAT_EN
    // -----------------------------------------------------------------------------------------
    // Hold-to-repeat FSM
    // -----------------------------------------------------------------------------------------
    rpt_state_e       r_state;
    rpt_state_e       w_state_d;
    logic [RPT_W-1:0] r_rcnt;
    logic [RPT_W-1:0] w_rcnt_d;
    logic             r_repeat;
    logic             w_repeat_d;
    logic             w_fire;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state  <= StIdle;
        r_rcnt   <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_d;
        r_rcnt   <= w_rcnt_d;
        r_repeat <= w_repeat_d;
      end
    end

    // Next-state logic. The FSM enters DELAY on the same edge the press pulse is set, so the
    // press cycle sees count 0 and the first repeat lands REPEAT_DELAY_CYC cycles later.
    always_comb begin
      w_state_d = r_state;
      w_rcnt_d  = r_rcnt;
      if (w_rise) begin
        w_state_d = StDelay;
        w_rcnt_d  = '0;
      end else if (w_fall || !r_level) begin
        w_state_d = StIdle;
        w_rcnt_d  = '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            w_rcnt_d = '0;
          end
          StDelay: begin
            if (r_rcnt == DLY_MAX) begin
              w_state_d = StRepeat;
              w_rcnt_d  = '0;
            end else begin
              w_rcnt_d = r_rcnt + RPT_W'(1);
            end
          end
          StRepeat: begin
            if (r_rcnt == RATE_MAX) begin
              w_rcnt_d = '0;
            end else begin
              w_rcnt_d = r_rcnt + RPT_W'(1);
            end
          end
          default: begin
            w_state_d = StIdle;
            w_rcnt_d  = '0;
          end
        endcase
      end
    end

    // Output logic: pulse at the end of each delay/rate period, suppressed on the release edge
    // so repeat and release never coincide.
    always_comb begin
      w_fire = ((r_state == StDelay) && (r_rcnt == DLY_MAX)) ||
               ((r_state == StRepeat) && (r_rcnt == RATE_MAX));
      w_repeat_d = w_fire && r_level && !w_fall;
    end

    assign o_btn_repeat[gi] = r_repeat;
`else
    assign o_btn_repeat[gi] = 1'b0;
`endif

  end

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed, table-driven bench for btn_conditioner with N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYC=8,
// REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5. Each table record drives a button pattern for a
// number of edges, then compares final outputs and the press/release pulses seen in the window.
// Reset-mid-count and auto-repeat are hand-written sequences.
// ---------------------------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned DEB    = 8;
  localparam int unsigned RDELAY = 20;
  localparam int unsigned RRATE  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] lvl;
  logic [N_CH-1:0] prs;
  logic [N_CH-1:0] rls;
  logic [N_CH-1:0] rpt;

  btn_conditioner #(
    .N_CH             (N_CH),
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYC     (DEB),
    .REPEAT_DELAY_CYC (RDELAY),
    .REPEAT_RATE_CYC  (RRATE)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn         (btn),
    .o_btn_level   (lvl),
    .o_btn_press   (prs),
    .o_btn_release (rls),
    .o_btn_repeat  (rpt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [N_CH-1:0] btn;
    int unsigned     edges;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] seen_p;
    logic [N_CH-1:0] seen_r;
  } vec_t;

  vec_t vecs[$];

  int n_tests = 0;
  int n_fail  = 0;
  int both_hi = 0;
  logic [N_CH-1:0] seen_p;
  logic [N_CH-1:0] seen_r;

  function automatic void add(input string name, input logic [N_CH-1:0] b, input int unsigned e,
                              input logic [N_CH-1:0] l, input logic [N_CH-1:0] p,
                              input logic [N_CH-1:0] r, input logic [N_CH-1:0] sp,
                              input logic [N_CH-1:0] sr);
    vec_t v;
    v.name = name; v.btn = b; v.edges = e; v.level = l; v.press = p; v.rel = r;
    v.seen_p = sp; v.seen_r = sr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each; collect pulses seen in the window.
  task automatic step(input int unsigned n);
    seen_p = '0;
    seen_r = '0;
    for (int k = 0; k < int'(n); k++) begin
      @(posedge clk);
      #1;
      seen_p = seen_p | prs;
      seen_r = seen_r | rls;
      if ((prs & rls) != '0) both_hi++;
    end
  endtask

  logic [63:0] rpt_pat;
  logic [63:0] rel_pat;
  logic [63:0] exp_rpt;
  logic [N_CH-1:0] rpt_other;

  initial begin
    // Test 1: clean press and release on channel 0
    add("t1_pre",      4'b0001,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t1_press",    4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    add("t1_after",    4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t1_hold",     4'b0001, 28, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t1_pre_rel",  4'b0000,  9, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t1_rel",      4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    add("t1_idle",     4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Test 2: bounce on channel 1 (3 high, 3 low, five times), then hold
    for (int i = 0; i < 5; i++) begin
      add("t2_bounce_hi", 4'b0010, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add("t2_bounce_lo", 4'b0000, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    add("t2_hold_pre", 4'b0010,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t2_press",    4'b0010,  1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    add("t2_pre_rel",  4'b0000,  9, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t2_rel",      4'b0000,  1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    add("t2_idle",     4'b0000,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Test 3: 7-cycle glitch on channel 2 never qualifies
    add("t3_glitch_hi", 4'b0100, 7, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t3_glitch_lo", 4'b0000, 20, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Test 4: simultaneous press on channels 0 and 3
    add("t4_pre",      4'b1001,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t4_press",    4'b1001,  1, 4'b1001, 4'b1001, 4'b0000, 4'b1001, 4'b0000);
    add("t4_after",    4'b1001,  1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t4_pre_rel",  4'b0000,  9, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("t4_rel",      4'b0000,  1, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b1001);
    add("t4_idle",     4'b0000,  3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Reset state
    rst = 1'b1;
    btn = '0;
    #12;
    check("reset_state", {48'd0, lvl, prs, rls, rpt}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    check("post_reset_idle", {48'd0, lvl, prs, rls, rpt}, 64'd0);

    // Table
    foreach (vecs[i]) begin
      btn = vecs[i].btn;
      step(vecs[i].edges);
      check(vecs[i].name, {44'd0, lvl, prs, rls, seen_p, seen_r},
            {44'd0, vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].seen_p, vecs[i].seen_r});
    end

    // Test 5: reset while channel 0 is mid-qualification and channel 3 is already pressed
    btn = 4'b1000;
    step(10);
    check("t5_ch3_press", {56'd0, lvl, prs}, {56'd0, 4'b1000, 4'b1000});
    btn = 4'b1001;
    step(7);  // channel 0 counter now at 5
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_async", {48'd0, lvl, prs, rls, rpt}, 64'd0);
    step(2);
    check("t5_rst_held", {56'd0, lvl, seen_r}, 64'd0);
    rst = 1'b0;
    step(9);
    check("t5_no_early", {52'd0, lvl, seen_p, seen_r}, 64'd0);
    step(1);
    check("t5_press", {52'd0, lvl, prs, seen_r}, {52'd0, 4'b1001, 4'b1001, 4'b0000});
    btn = 4'b0000;
    step(10);
    check("t5_release", {56'd0, lvl, rls}, {56'd0, 4'b0000, 4'b1001});
    step(2);

    // Test 6: hold channel 1; debounced release lands 38 cycles after the press cycle
    btn = 4'b0010;
    step(10);
    check("t6_press", {56'd0, lvl, prs}, {56'd0, 4'b0010, 4'b0010});
    rpt_pat   = '0;
    rel_pat   = '0;
    rpt_other = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 29) btn = 4'b0000;
      @(posedge clk);
      #1;
      if (rpt[1]) rpt_pat[k] = 1'b1;
      if (rls[1]) rel_pat[k] = 1'b1;
      rpt_other = rpt_other | (rpt & 4'b1101);
      if ((rpt & rls) != '0) both_hi++;
      if ((prs & rls) != '0) both_hi++;
    end
    exp_rpt = '0;
`ifdef BTN_AUTOREPEAT_EN
    exp_rpt[20] = 1'b1;
    exp_rpt[25] = 1'b1;
    exp_rpt[30] = 1'b1;
    exp_rpt[35] = 1'b1;
`endif
    check("t6_repeat_pattern", rpt_pat, exp_rpt);
    check("t6_release_at_38", rel_pat, 64'd1 << 38);
    check("t6_other_ch_repeat", {60'd0, rpt_other}, 64'd0);

    check("pulse_exclusive", 64'(both_hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
